// File: rtl/park_pkg.sv
// ============================================================================
// Module   : park_pkg
// Purpose  : Shared types, sin table and round/saturate helper for Park stages
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package park_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        M0    = 3'd2,
        M1    = 3'd3,
        M2    = 3'd4,
        M3    = 3'd5,
        OUT   = 3'd6
    } state_t;

    localparam int c_def_d_width    = 18;
    localparam int c_def_q_bits     = 15;
    localparam int c_def_angle_bits = 10;
    localparam int c_def_tab_n      = (1 << (c_def_angle_bits - 2)) + 1;

    // pi in Q60
    localparam logic signed [127:0] c_pi_q60 = 128'sh3243F6A8885A308D;

    // round(sin(idx*pi/2^(angle_bits-1)) * 2^q_bits), Taylor series in Q60
    function automatic logic signed [31:0] sin_entry(input int idx, input int angle_bits,
                                                     input int q_bits);
        logic signed [127:0] x;
        logic signed [127:0] term;
        logic signed [127:0] sum;
        logic signed [127:0] den;
        logic signed [127:0] r;
        x    = (128'(idx) * c_pi_q60) >>> (angle_bits - 1);
        term = x;
        sum  = x;
        for (int k = 1; k <= 12; k++) begin
            term = (term * x) >>> 60;
            term = (term * x) >>> 60;
            den  = 128'(2 * k * (2 * k + 1));
            term = -(term / den);
            sum  = sum + term;
        end
        r = ((sum <<< q_bits) + (128'sd1 <<< 59)) >>> 60;
        if (idx == (1 << (angle_bits - 2)))
            r = 128'sd1 <<< q_bits;
        return 32'(r);
    endfunction

    function automatic logic [c_def_tab_n*c_def_d_width-1:0] gen_sin_table();
        logic [c_def_tab_n*c_def_d_width-1:0] t;
        t = '0;
        for (int i = 0; i < c_def_tab_n; i++)
            t[i*c_def_d_width +: c_def_d_width] =
                c_def_d_width'(sin_entry(i, c_def_angle_bits, c_def_q_bits));
        return t;
    endfunction

    // Quarter-wave table for the default parameter set, entry i at bits [i*18 +: 18]
    localparam logic [c_def_tab_n*c_def_d_width-1:0] SIN_TABLE = gen_sin_table();

    // Returns {sat, value}: round-half-up by q_bits, clip to signed d_width
    function automatic logic [64:0] round_sat(input logic signed [63:0] acc, input int q_bits,
                                              input int d_width);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        logic               s;
        r  = (acc + (64'sd1 <<< (q_bits - 1))) >>> q_bits;
        hi = (64'sd1 <<< (d_width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (d_width - 1));
        s  = 1'b0;
        if (r > hi) begin
            r = hi;
            s = 1'b1;
        end else if (r < lo) begin
            r = lo;
            s = 1'b1;
        end
        return {s, r};
    endfunction

endpackage

`default_nettype wire

// File: rtl/park_sincos.sv
// ============================================================================
// Module   : park_sincos
// Purpose  : Registered sin/cos lookup with quarter-wave folding, 1-cycle latency
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module park_sincos
    import park_pkg::*;
#(
    parameter int D_WIDTH    = 18,
    parameter int Q_BITS     = 15,
    parameter int ANGLE_BITS = 10
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic [ANGLE_BITS-1:0]     i_theta,
    output logic signed [D_WIDTH-1:0] o_sin,
    output logic signed [D_WIDTH-1:0] o_cos
);

    localparam int c_idx_w = ANGLE_BITS - 2;
    localparam int c_iw    = c_idx_w + 1;
    localparam int c_h     = 1 << c_idx_w;
    localparam int c_tab_n = c_h + 1;

    logic signed [D_WIDTH-1:0] w_tab [0:c_tab_n-1];

    if (D_WIDTH == c_def_d_width && Q_BITS == c_def_q_bits &&
        ANGLE_BITS == c_def_angle_bits) begin : g_pkg_table
        for (genvar gi = 0; gi < c_tab_n; gi++) begin : g_entry
            assign w_tab[gi] = SIN_TABLE[gi*D_WIDTH +: D_WIDTH];
        end
    end else begin : g_calc_table
        for (genvar gi = 0; gi < c_tab_n; gi++) begin : g_entry
            localparam logic signed [D_WIDTH-1:0] c_val =
                D_WIDTH'(sin_entry(gi, ANGLE_BITS, Q_BITS));
            assign w_tab[gi] = c_val;
        end
    end

    logic [1:0]                w_quad;
    logic [c_iw-1:0]           w_idx_lo;
    logic [c_iw-1:0]           w_idx_hi;
    logic signed [D_WIDTH-1:0] w_t_lo;
    logic signed [D_WIDTH-1:0] w_t_hi;
    logic signed [D_WIDTH-1:0] w_sin;
    logic signed [D_WIDTH-1:0] w_cos;

    assign w_quad   = i_theta[ANGLE_BITS-1 -: 2];
    assign w_idx_lo = {1'b0, i_theta[c_idx_w-1:0]};
    assign w_idx_hi = c_iw'(c_h) - w_idx_lo;
    assign w_t_lo   = w_tab[w_idx_lo];
    assign w_t_hi   = w_tab[w_idx_hi];

    always_comb begin
        w_sin = w_t_lo;
        w_cos = w_t_hi;
        case (w_quad)
            2'd0: begin w_sin = w_t_lo;  w_cos = w_t_hi;  end
            2'd1: begin w_sin = w_t_hi;  w_cos = -w_t_lo; end
            2'd2: begin w_sin = -w_t_lo; w_cos = -w_t_hi; end
            default: begin w_sin = -w_t_hi; w_cos = w_t_lo; end
        endcase
    end

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            o_sin <= '0;
            o_cos <= '0;
        end else begin
            o_sin <= w_sin;
            o_cos <= w_cos;
        end
    end

endmodule

`default_nettype wire

// File: rtl/park.sv
// ============================================================================
// Module   : park
// Purpose  : Park transform (alpha/beta -> d/q) on one shared multiplier
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module park
    import park_pkg::*;
#(
    parameter int D_WIDTH    = 18,
    parameter int Q_BITS     = 15,
    parameter int ANGLE_BITS = 10
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic signed [D_WIDTH-1:0] alpha,
    input  logic signed [D_WIDTH-1:0] beta,
    input  logic [ANGLE_BITS-1:0]     theta,
    input  logic                      start,
    output logic signed [D_WIDTH-1:0] d,
    output logic signed [D_WIDTH-1:0] q,
    output logic                      busy,
    output logic                      done,
    output logic                      sat
);

    localparam int c_prod_w = 2 * D_WIDTH;
    localparam int c_acc_w  = 2 * D_WIDTH + 1;

    state_t r_state;
    state_t w_next;

    logic signed [D_WIDTH-1:0]  r_alpha;
    logic signed [D_WIDTH-1:0]  r_beta;
    logic [ANGLE_BITS-1:0]      r_theta;
    logic signed [c_acc_w-1:0]  r_acc_d;
    logic signed [c_acc_w-1:0]  r_acc_q;

    logic signed [D_WIDTH-1:0]  w_sin;
    logic signed [D_WIDTH-1:0]  w_cos;
    logic signed [D_WIDTH-1:0]  w_mul_a;
    logic signed [D_WIDTH-1:0]  w_mul_b;
    logic signed [c_prod_w-1:0] w_prod;
    logic signed [c_acc_w-1:0]  w_prod_x;
    logic [64:0]                w_rs_d;
    logic [64:0]                w_rs_q;
    logic [2*(64-D_WIDTH)-1:0]  w_unused_hi;

    park_sincos #(
        .D_WIDTH    (D_WIDTH),
        .Q_BITS     (Q_BITS),
        .ANGLE_BITS (ANGLE_BITS)
    ) u_sincos (
        .clk     (clk),
        .rstb    (rstb),
        .i_theta (r_theta),
        .o_sin   (w_sin),
        .o_cos   (w_cos)
    );

    // M0: alpha*cos, M1: beta*sin, M2: alpha*sin, M3: beta*cos
    assign w_mul_a  = (r_state == M0 || r_state == M2) ? r_alpha : r_beta;
    assign w_mul_b  = (r_state == M0 || r_state == M3) ? w_cos : w_sin;
    assign w_prod   = c_prod_w'(w_mul_a) * c_prod_w'(w_mul_b);
    assign w_prod_x = c_acc_w'(w_prod);

    assign w_rs_d      = round_sat(64'(r_acc_d), Q_BITS, D_WIDTH);
    assign w_rs_q      = round_sat(64'(r_acc_q), Q_BITS, D_WIDTH);
    // Clipped results are sign extensions above D_WIDTH
    assign w_unused_hi = {w_rs_d[63:D_WIDTH], w_rs_q[63:D_WIDTH]};

    assign busy = (r_state != IDLE);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = FETCH;
            FETCH:   w_next = M0;
            M0:      w_next = M1;
            M1:      w_next = M2;
            M2:      w_next = M3;
            M3:      w_next = OUT;
            OUT:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            r_alpha <= '0;
            r_beta  <= '0;
            r_theta <= '0;
            r_acc_d <= '0;
            r_acc_q <= '0;
            d       <= '0;
            q       <= '0;
            sat     <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_alpha <= alpha;
                        r_beta  <= beta;
                        r_theta <= theta;
                    end
                end
                M0: r_acc_d <= w_prod_x;
                M1: r_acc_d <= r_acc_d + w_prod_x;
                M2: r_acc_q <= -w_prod_x;
                M3: r_acc_q <= r_acc_q + w_prod_x;
                OUT: begin
                    d    <= w_rs_d[D_WIDTH-1:0];
                    q    <= w_rs_q[D_WIDTH-1:0];
                    sat  <= w_rs_d[64] | w_rs_q[64];
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
